// File: rtl/stream_window_sum.sv
// Sums consecutive windows of up to N input samples and queues {sum, length}
// per window in a 2-entry output FIFO; i_flush closes a partial window early.
module stream_window_sum #(
    parameter int unsigned DW = 4,
    parameter int unsigned N  = 10,
    localparam int unsigned CW = $clog2(N + 1),
    localparam int unsigned SW = DW + CW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_valid,
    output logic          i_ready,
    input  logic [DW-1:0] i_data,
    input  logic          i_flush,
    output logic          o_valid,
    input  logic          o_ready,
    output logic [SW-1:0] o_sum,
    output logic [CW-1:0] o_len
);

    logic          rst_q;
    logic [SW-1:0] acc_q, acc_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [SW-1:0] sum_mem_q [2];
    logic [CW-1:0] len_mem_q [2];
    logic          wr_ptr_q, rd_ptr_q;
    logic [1:0]    count_q, count_d;

    logic          full;
    logic          accept;
    logic          pop;
    logic          push;
    logic [SW-1:0] acc_nxt;
    logic [CW-1:0] cnt_nxt;

    // Handshakes, window accumulation and close decision
    always_comb begin
        full    = (count_q == 2'd2);
        i_ready = !rst_q && !full;
        o_valid = (count_q != 2'd0);
        o_sum   = o_valid ? sum_mem_q[rd_ptr_q] : '0;
        o_len   = o_valid ? len_mem_q[rd_ptr_q] : '0;

        accept  = i_valid && i_ready;
        pop     = o_valid && o_ready;
        acc_nxt = accept ? acc_q + SW'(i_data) : acc_q;
        cnt_nxt = accept ? cnt_q + CW'(1) : cnt_q;

        // A flush never pushes into a full FIFO, so nothing is ever overwritten
        push    = (accept && (cnt_q == CW'(N - 1)))
               || (i_flush && !full && ((cnt_q != '0) || accept));

        acc_d   = push ? '0 : acc_nxt;
        cnt_d   = push ? '0 : cnt_nxt;

        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    // rst_q holds i_ready low for the first cycle after reset release
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rst_q        <= 1'b1;
            acc_q        <= '0;
            cnt_q        <= '0;
            count_q      <= 2'd0;
            wr_ptr_q     <= 1'b0;
            rd_ptr_q     <= 1'b0;
            sum_mem_q[0] <= '0;
            sum_mem_q[1] <= '0;
            len_mem_q[0] <= '0;
            len_mem_q[1] <= '0;
        end else begin
            rst_q   <= 1'b0;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            count_q <= count_d;
            if (push) begin
                sum_mem_q[wr_ptr_q] <= acc_nxt;
                len_mem_q[wr_ptr_q] <= cnt_nxt;
                wr_ptr_q            <= !wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= !rd_ptr_q;
            end
        end
    end

endmodule

// File: tb/tb_stream_window_sum.sv
// Randomized and directed checks of stream_window_sum against a queue-based
// model of window sums and FIFO contents.
module tb_stream_window_sum;

    localparam int unsigned DW = 4;
    localparam int unsigned N  = 10;
    localparam int unsigned CW = $clog2(N + 1);
    localparam int unsigned SW = DW + CW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          i_valid = 1'b0;
    logic          i_ready;
    logic [DW-1:0] i_data = '0;
    logic          i_flush = 1'b0;
    logic          o_valid;
    logic          o_ready = 1'b0;
    logic [SW-1:0] o_sum;
    logic [CW-1:0] o_len;

    int n_cmp = 0;
    int n_err = 0;

    // model: open window plus queue of closed windows awaiting pop
    int macc = 0;
    int mcnt = 0;
    int qs[$];
    int ql[$];

    stream_window_sum #(.DW(DW), .N(N)) dut (
        .clk    (clk),
        .rst    (rst),
        .i_valid(i_valid),
        .i_ready(i_ready),
        .i_data (i_data),
        .i_flush(i_flush),
        .o_valid(o_valid),
        .o_ready(o_ready),
        .o_sum  (o_sum),
        .o_len  (o_len)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // One cycle: drive, check outputs against the model, advance the model
    task automatic step(input bit v, input int d, input bit f, input bit r, output bit acc);
        bit full;
        int nacc;
        int ncnt;
        i_valid = v;
        i_data  = 4'(d);
        i_flush = f;
        o_ready = r;
        #1;
        full = (qs.size() == 2);
        chk("i_ready", int'(i_ready), int'(!full));
        chk("o_valid", int'(o_valid), int'(qs.size() != 0));
        chk("o_sum", int'(o_sum), (qs.size() != 0) ? qs[0] : 0);
        chk("o_len", int'(o_len), (ql.size() != 0) ? ql[0] : 0);
        acc = v && !full;
        if (r && qs.size() != 0) begin
            void'(qs.pop_front());
            void'(ql.pop_front());
        end
        nacc = macc + (acc ? d : 0);
        ncnt = mcnt + (acc ? 1 : 0);
        if ((acc && ncnt == N) || (f && !full && ncnt != 0)) begin
            qs.push_back(nacc);
            ql.push_back(ncnt);
            macc = 0;
            mcnt = 0;
        end else begin
            macc = nacc;
            mcnt = ncnt;
        end
        @(negedge clk);
    endtask

    // Offer one sample until accepted; rnd makes o_ready random per attempt
    task automatic feed(input int d, input bit f, input bit r, input bit rnd);
        bit acc = 0;
        for (int t = 0; t < 100 && !acc; t++) begin
            step(1'b1, d, f, rnd ? bit'($urandom_range(1)) : r, acc);
        end
        if (!acc) chk("feed_accept", int'(acc), 1);
    endtask

    task automatic idle(input int cycles, input bit r);
        bit acc;
        for (int t = 0; t < cycles; t++) step(1'b0, 0, 1'b0, r, acc);
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        i_valid = 1'b0;
        i_flush = 1'b0;
        #1;
        chk("rst_o_valid", int'(o_valid), 0);
        chk("rst_i_ready", int'(i_ready), 0);
        chk("rst_o_sum", int'(o_sum), 0);
        chk("rst_o_len", int'(o_len), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("release_i_ready", int'(i_ready), 0);
        macc = 0;
        mcnt = 0;
        qs.delete();
        ql.delete();
        @(negedge clk);
    endtask

    initial begin
        bit acc;
        @(negedge clk);
        do_reset();

        // 1: full window 1..10
        for (int k = 1; k <= 10; k++) feed(k, 1'b0, 1'b1, 1'b0);
        chk("t1_valid", int'(o_valid), 1);
        chk("t1_sum", int'(o_sum), 55);
        chk("t1_len", int'(o_len), 10);
        idle(2, 1'b1);

        // 2: partial window closed by a lone flush; second flush is a no-op
        for (int k = 1; k <= 3; k++) feed(k, 1'b0, 1'b1, 1'b0);
        step(1'b0, 0, 1'b1, 1'b1, acc);
        chk("t2_sum", int'(o_sum), 6);
        chk("t2_len", int'(o_len), 3);
        step(1'b0, 0, 1'b1, 1'b1, acc);
        idle(1, 1'b1);
        chk("t2_empty", int'(o_valid), 0);

        // 3: fill the FIFO with o_ready low, then stall the 21st sample
        for (int k = 0; k < 20; k++) feed(15, 1'b0, 1'b0, 1'b0);
        chk("t3_ready_full", int'(i_ready), 0);
        for (int k = 0; k < 3; k++) step(1'b1, 15, 1'b0, 1'b0, acc);
        chk("t3_sum_held", int'(o_sum), 150);
        chk("t3_len_held", int'(o_len), 10);
        step(1'b1, 15, 1'b1, 1'b0, acc);
        feed(15, 1'b0, 1'b1, 1'b0);
        chk("t3_window_cnt", mcnt, 1);
        step(1'b0, 0, 1'b1, 1'b1, acc);
        idle(4, 1'b1);

        // 4: flush together with the first sample of a window
        feed(7, 1'b1, 1'b1, 1'b0);
        chk("t4_sum", int'(o_sum), 7);
        chk("t4_len", int'(o_len), 1);
        idle(2, 1'b1);

        // 5: reset mid-window discards the partial sum
        for (int k = 0; k < 5; k++) feed(9, 1'b0, 1'b1, 1'b0);
        do_reset();
        for (int k = 1; k <= 10; k++) feed(k, 1'b0, 1'b1, 1'b0);
        chk("t5_sum", int'(o_sum), 55);
        chk("t5_len", int'(o_len), 10);
        idle(2, 1'b1);
        chk("t5_empty", int'(o_valid), 0);

        // 6: random throttling on both sides with occasional flushes
        for (int k = 0; k < 200; k++) begin
            int gap = $urandom_range(1);
            for (int g = 0; g < gap; g++)
                step(1'b0, 0, ($urandom_range(9) == 0), bit'($urandom_range(1)), acc);
            feed($urandom_range(15), ($urandom_range(9) == 0), 1'b0, 1'b1);
        end
        step(1'b0, 0, 1'b1, 1'b1, acc);
        for (int t = 0; t < 20 && qs.size() != 0; t++) idle(1, 1'b1);
        idle(1, 1'b1);
        chk("t6_drained", int'(o_valid), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
